// File: rtl/mem_responder_if.sv
// mem_responder_if: per-channel valid/ready read and write request bus
interface mem_responder_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address;
    logic [NUM_CHANNELS-1:0]                read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data;
    logic [NUM_CHANNELS-1:0]                write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data;
    logic [NUM_CHANNELS-1:0]                write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multi-channel fixed-latency memory target with backdoor preload port
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 1,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    input  logic                 load_enable,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LOAD   = 4'(LATENCY - 1);
    localparam bit         DIRECT = LATENCY == 1;

    logic [DATA_BITS-1:0]                   mem [DEPTH];
    logic [2*NUM_CHANNELS-1:0]              active;
    logic [NUM_CHANNELS-1:0]                commit;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data;

    assign busy = |active;

    genvar c;
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        state_t               rd_state, rd_next;
        logic [3:0]           rd_count;
        logic [ADDR_BITS-1:0] rd_address, rd_sel;
        logic [DATA_BITS-1:0] rd_data;
        logic                 rd_fire, rd_valid;

        assign rd_valid = bus.read_valid[c];

        // read-side next state; rd_fire marks the edge on which data is sampled from storage
        always_comb begin
            rd_next = rd_state;
            rd_fire = 1'b0;
            rd_sel  = rd_address;
            case (rd_state)
                IDLE: if (rd_valid) begin
                    rd_next = DIRECT ? RESP : WAIT;
                    rd_fire = DIRECT;
                    rd_sel  = bus.read_address[c];
                end
                WAIT: begin
                    rd_next = !rd_valid ? IDLE : rd_count == 4'd1 ? RESP : WAIT;
                    rd_fire = rd_valid && rd_count == 4'd1;
                end
                RESP:    rd_next = rd_valid ? RESP : IDLE;
                default: rd_next = IDLE;
            endcase
        end

        // read-side state, latency counter, latched address and held response data
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_state   <= IDLE;
                rd_count   <= '0;
                rd_address <= '0;
                rd_data    <= '0;
            end else begin
                rd_state <= rd_next;
                if (rd_state == IDLE && rd_valid) begin
                    rd_count   <= LOAD;
                    rd_address <= bus.read_address[c];
                end else if (rd_state == WAIT) begin
                    rd_count <= rd_count - 4'd1;
                end
                if (rd_fire) rd_data <= mem[rd_sel];
            end
        end

        assign bus.read_ready[c] = rd_state == RESP;
        assign bus.read_data[c]  = rd_data;
        assign active[c]         = rd_state != IDLE;

        if (WRITE_ENABLE != 0) begin : g_wr
            state_t               wr_state, wr_next;
            logic [3:0]           wr_count;
            logic [ADDR_BITS-1:0] wr_address;
            logic [DATA_BITS-1:0] wr_data;
            logic                 wr_valid, wr_fire;

            assign wr_valid = bus.write_valid[c];

            // write-side next state; wr_fire marks the edge on which the word is committed
            always_comb begin
                wr_next = wr_state;
                wr_fire = 1'b0;
                case (wr_state)
                    IDLE: if (wr_valid) begin
                        wr_next = DIRECT ? RESP : WAIT;
                        wr_fire = DIRECT;
                    end
                    WAIT: begin
                        wr_next = !wr_valid ? IDLE : wr_count == 4'd1 ? RESP : WAIT;
                        wr_fire = wr_valid && wr_count == 4'd1;
                    end
                    RESP:    wr_next = wr_valid ? RESP : IDLE;
                    default: wr_next = IDLE;
                endcase
            end

            // write-side state, latency counter, latched address and data
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_state   <= IDLE;
                    wr_count   <= '0;
                    wr_address <= '0;
                    wr_data    <= '0;
                end else begin
                    wr_state <= wr_next;
                    if (wr_state == IDLE && wr_valid) begin
                        wr_count   <= LOAD;
                        wr_address <= bus.write_address[c];
                        wr_data    <= bus.write_data[c];
                    end else if (wr_state == WAIT) begin
                        wr_count <= wr_count - 4'd1;
                    end
                end
            end

            assign commit[c]               = wr_fire;
            assign commit_address[c]       = wr_state == IDLE ? bus.write_address[c] : wr_address;
            assign commit_data[c]          = wr_state == IDLE ? bus.write_data[c] : wr_data;
            assign bus.write_ready[c]      = wr_state == RESP;
            assign active[NUM_CHANNELS+c]  = wr_state != IDLE;
        end else begin : g_no_wr
            assign commit[c]              = 1'b0;
            assign commit_address[c]      = '0;
            assign commit_data[c]         = '0;
            assign bus.write_ready[c]     = 1'b0;
            assign active[NUM_CHANNELS+c] = 1'b0;
        end
    end

    // storage: preload applied first, then channel commits in index order so the highest channel wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (load_enable) mem[load_address] <= load_data;
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (commit[i]) mem[commit_address[i]] <= commit_data[i];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder
module tb_mem_responder;
    localparam int LAT = 3;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic       ld_en, ld_en1, busy, busy1;
    logic [7:0] ld_addr, ld_data, ld_addr1, ld_data1;
    logic [3:0] rv, wv;
    logic [3:0][7:0] ra, wa, wd;

    logic [7:0] ref_mem [256];
    exp_t       rq [4][$];
    int         wq [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4)) b ();
    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4)) b1 ();

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(LAT), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .bus(b),
        .load_enable(ld_en), .load_address(ld_addr), .load_data(ld_data), .busy(busy)
    );

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(1), .WRITE_ENABLE(0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1),
        .load_enable(ld_en1), .load_address(ld_addr1), .load_data(ld_data1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the expected response whenever a ready rises on the main DUT
    initial begin
        logic [3:0] rprev, wprev;
        logic [7:0] held [4];
        exp_t       e;
        int         w;
        rprev = '0;
        wprev = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rprev = '0;
                wprev = '0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (b.read_ready[c] && !rprev[c]) begin
                        if (rq[c].size() == 0) begin
                            check($sformatf("read_unexpected_ready[%0d]", c), 32'(b.read_ready[c]), 0);
                        end else begin
                            e = rq[c].pop_front();
                            held[c] = e.data;
                            check($sformatf("read_data[%0d]", c), 32'(b.read_data[c]), 32'(e.data));
                            check($sformatf("read_latency[%0d]", c), 32'(cyc), 32'(e.at));
                        end
                    end else if (b.read_ready[c]) begin
                        check($sformatf("read_hold[%0d]", c), 32'(b.read_data[c]), 32'(held[c]));
                    end
                    if (b.write_ready[c] && !wprev[c]) begin
                        if (wq[c].size() == 0) begin
                            check($sformatf("write_unexpected_ready[%0d]", c), 32'(b.write_ready[c]), 0);
                        end else begin
                            w = wq[c].pop_front();
                            check($sformatf("write_latency[%0d]", c), 32'(cyc), 32'(w));
                        end
                    end
                end
                rprev = b.read_ready;
                wprev = b.write_ready;
            end
        end
    end

    // one transaction round on the main DUT: all requests accepted on the same edge
    task automatic round(input logic [3:0] r, input logic [3:0] w,
                         input logic [3:0][7:0] raddr, input logic [3:0][7:0] waddr,
                         input logic [3:0][7:0] wdata, input int lph,
                         input logic [7:0] la, input logic [7:0] ld, input int hold);
        int   n;
        exp_t e;
        n = cyc + 1;
        ld_addr = la;
        ld_data = ld;
        ld_en = lph == 1;
        if (lph == 1) ref_mem[la] = ld;
        for (int c = 0; c < 4; c++) begin
            if (r[c]) begin
                e.data = ref_mem[raddr[c]];
                e.at = n + LAT - 1;
                rq[c].push_back(e);
            end
        end
        if (lph == 2) ref_mem[la] = ld;
        for (int c = 0; c < 4; c++) begin
            if (w[c]) begin
                ref_mem[waddr[c]] = wdata[c];
                wq[c].push_back(n + LAT - 1);
            end
        end
        b.read_valid = r;
        b.read_address = raddr;
        b.write_valid = w;
        b.write_address = waddr;
        b.write_data = wdata;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            ld_en = lph == 2 && k == LAT - 1;
            if (k == 1) begin
                if ((r | w) != 0) check("busy_during_request", 32'(busy), 1);
                b.read_address = $urandom;
                b.write_address = $urandom;
                b.write_data = $urandom;
            end
        end
        ld_en = 1'b0;
        repeat (hold) @(negedge clk);
        b.read_valid = '0;
        b.write_valid = '0;
        @(negedge clk);
        check("release_ready", 32'({b.read_ready, b.write_ready}), 0);
        check("release_busy", 32'(busy), 0);
    endtask

    // request accepted and then withdrawn while still waiting
    task automatic abort_req(input logic [3:0] r, input logic [3:0] w,
                             input logic [3:0][7:0] raddr, input logic [3:0][7:0] waddr,
                             input logic [3:0][7:0] wdata);
        b.read_valid = r;
        b.read_address = raddr;
        b.write_valid = w;
        b.write_address = waddr;
        b.write_data = wdata;
        @(negedge clk);
        check("abort_busy_high", 32'(busy), 1);
        b.read_valid = '0;
        b.write_valid = '0;
        @(negedge clk);
        check("abort_busy_low", 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        b.read_valid = '0; b.read_address = '0; b.write_valid = '0; b.write_address = '0; b.write_data = '0;
        b1.read_valid = '0; b1.read_address = '0; b1.write_valid = '0; b1.write_address = '0; b1.write_data = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        ld_en1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_busy1", 32'(busy1), 0);
        check("reset_ready", 32'({b.read_ready, b.write_ready}), 0);
        check("reset_read_data", 32'(b.read_data), 0);
        @(negedge clk);
        reset = 1'b1;

        // LATENCY=1 responder: preload then read
        ld_en1 = 1'b1; ld_addr1 = 8'h10; ld_data1 = 8'h5A;
        @(negedge clk);
        ld_en1 = 1'b0;
        b1.read_valid[0] = 1'b1; b1.read_address[0] = 8'h10;
        @(negedge clk);
        check("lat1_ready", 32'(b1.read_ready[0]), 1);
        check("lat1_data", 32'(b1.read_data[0]), 32'h5A);
        b1.read_address[0] = 8'h33;
        @(negedge clk);
        check("lat1_ready_held", 32'(b1.read_ready[0]), 1);
        check("lat1_data_held", 32'(b1.read_data[0]), 32'h5A);
        b1.read_valid[0] = 1'b0;
        @(negedge clk);
        check("lat1_ready_low", 32'(b1.read_ready[0]), 0);
        check("lat1_busy_low", 32'(busy1), 0);

        // write-disabled responder ignores write requests
        ld_en1 = 1'b1; ld_addr1 = 8'h20; ld_data1 = 8'hC3;
        @(negedge clk);
        ld_en1 = 1'b0;
        b1.write_valid[1] = 1'b1; b1.write_address[1] = 8'h20; b1.write_data[1] = 8'hEE;
        repeat (5) begin
            @(negedge clk);
            check("we0_write_ready", 32'(b1.write_ready[1]), 0);
            check("we0_busy", 32'(busy1), 0);
        end
        b1.write_valid[1] = 1'b0;
        b1.read_valid[1] = 1'b1; b1.read_address[1] = 8'h20;
        @(negedge clk);
        check("we0_read_ready", 32'(b1.read_ready[1]), 1);
        check("we0_mem_unchanged", 32'(b1.read_data[1]), 32'hC3);
        b1.read_valid[1] = 1'b0;
        @(negedge clk);

        // same-edge write and read: read returns old contents, then new
        ra = '0; wa = '0; wd = '0;
        ra[3] = 8'h80; wa[2] = 8'h80; wd[2] = 8'h33;
        round(4'b1000, 4'b0100, ra, wa, wd, 0, 8'h00, 8'h00, 1);
        round(4'b1000, 4'b0000, ra, wa, wd, 0, 8'h00, 8'h00, 0);

        // two channels write the same word on one edge
        wa = '0; wd = '0; ra = '0;
        wa[0] = 8'h05; wd[0] = 8'h11; wa[3] = 8'h05; wd[3] = 8'h22; ra[1] = 8'h05;
        round(4'b0000, 4'b1001, ra, wa, wd, 0, 8'h00, 8'h00, 0);
        round(4'b0010, 4'b0000, ra, wa, wd, 0, 8'h00, 8'h00, 2);

        // channel write beats preload on the commit edge; preload visible to a later read
        wa = '0; wd = '0; ra = '0;
        wa[0] = 8'h40; wd[0] = 8'h77; ra[2] = 8'h40;
        round(4'b0000, 4'b0001, ra, wa, wd, 2, 8'h40, 8'h99, 0);
        round(4'b0100, 4'b0000, ra, wa, wd, 0, 8'h00, 8'h00, 0);
        ra = '0; ra[0] = 8'h60;
        round(4'b0001, 4'b0000, ra, wa, wd, 1, 8'h60, 8'hA5, 1);

        // aborted read and write: no ready, no commit
        ra = '0; wa = '0; wd = '0;
        ra[1] = 8'h80; wa[0] = 8'h80; wd[0] = 8'hFF;
        abort_req(4'b0010, 4'b0001, ra, wa, wd);
        ra = '0; ra[2] = 8'h80;
        round(4'b0100, 4'b0000, ra, wa, wd, 0, 8'h00, 8'h00, 0);

        // asynchronous reset in the middle of a write
        b.write_valid = 4'b0001; b.write_address[0] = 8'h30; b.write_data[0] = 8'hAB;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 0);
        check("midreset_ready", 32'({b.read_ready, b.write_ready}), 0);
        check("midreset_read_data", 32'(b.read_data), 0);
        b.write_valid = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        ra = '0; ra[0] = 8'h30; ra[1] = 8'h80;
        round(4'b0011, 4'b0000, ra, wa, wd, 0, 8'h00, 8'h00, 0);

        // randomized rounds over a small address window to force collisions
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 4; c++) begin
                ra[c] = 8'($urandom_range(0, 7));
                wa[c] = 8'($urandom_range(0, 7));
                wd[c] = 8'($urandom);
            end
            round(4'($urandom), 4'($urandom), ra, wa, wd, $urandom_range(0, 2),
                  8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));
        end

        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("read_queue_drained[%0d]", c), 32'(rq[c].size()), 0);
            check($sformatf("write_queue_drained[%0d]", c), 32'(wq[c].size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
